// File: rtl/trap_pkg.sv
// Shared types and constants for the trap sequencer and its vector calculator.
package trap_pkg;

    localparam int CPU_WIDTH = 32'd64;
    localparam int INT_BIT   = CPU_WIDTH - 32'd1;

    localparam int unsigned TIMER_CAUSE = 32'd7;
    localparam int unsigned SOFT_CAUSE  = 32'd3;

    localparam logic [1:0] MTVEC_VECTORED = 2'b01;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        TRAP     = 2'd1,
        MRET     = 2'd2,
        REDIRECT = 2'd3
    } trap_state_e;

    typedef enum logic [1:0] {
        EXC  = 2'd0,
        RET  = 2'd1,
        TINT = 2'd2,
        SINT = 2'd3
    } trap_kind_e;

    function automatic logic [CPU_WIDTH-1:0] align4(input logic [CPU_WIDTH-1:0] addr);
        return addr & ~{{(CPU_WIDTH-2){1'b0}}, 2'b11};
    endfunction

    // Interrupt mcause: top bit set, code in the low bits.
    function automatic logic [CPU_WIDTH-1:0] int_cause(input int unsigned code);
        return {1'b1, (CPU_WIDTH-1)'(code)};
    endfunction

endpackage

// File: rtl/trap_ctrl_if.sv
// Writeback / CSR / fetch signal bundle around the trap sequencer.
interface trap_ctrl_if;
    import trap_pkg::*;

    logic                 wb_valid;
    logic [CPU_WIDTH-1:0] wb_pc;
    logic [31:0]          wb_ins;
    logic                 ex_req;
    logic [CPU_WIDTH-1:0] ex_code;
    logic                 mret_req;
    logic                 mtime_int;
    logic                 msip;
    logic                 mstatus_mie;
    logic                 mie_mtie;
    logic                 mie_msie;
    logic [CPU_WIDTH-1:0] mtvec;
    logic [CPU_WIDTH-1:0] mepc;
    logic                 redirect_ready;

    logic                 wb_ready;
    logic                 flush;
    logic                 trap_valid;
    logic [CPU_WIDTH-1:0] trap_cause;
    logic [CPU_WIDTH-1:0] trap_epc;
    logic                 mret_valid;
    logic                 redirect_valid;
    logic [CPU_WIDTH-1:0] redirect_pc;
    logic                 busy;

    modport slave (
        input  wb_valid, wb_pc, wb_ins, ex_req, ex_code, mret_req,
               mtime_int, msip, mstatus_mie, mie_mtie, mie_msie,
               mtvec, mepc, redirect_ready,
        output wb_ready, flush, trap_valid, trap_cause, trap_epc,
               mret_valid, redirect_valid, redirect_pc, busy
    );

    modport master (
        output wb_valid, wb_pc, wb_ins, ex_req, ex_code, mret_req,
               mtime_int, msip, mstatus_mie, mie_mtie, mie_msie,
               mtvec, mepc, redirect_ready,
        input  wb_ready, flush, trap_valid, trap_cause, trap_epc,
               mret_valid, redirect_valid, redirect_pc, busy
    );

endinterface

// File: rtl/trap_vec_calc.sv
// Trap target from mtvec and cause; shared with the vectored-mode CSR read path.
module trap_vec_calc
    import trap_pkg::*;
(
    input  logic [CPU_WIDTH-1:0] mtvec,
    input  logic [CPU_WIDTH-2:0] cause_code,
    input  logic                 is_int,
    output logic [CPU_WIDTH-1:0] target
);

    logic [CPU_WIDTH-1:0] base_s;
    logic [CPU_WIDTH-1:0] offset_s;

    assign base_s   = align4(mtvec);
    assign offset_s = CPU_WIDTH'({cause_code, 2'b00});

    // Only interrupts are vectored; mode 1x falls back to direct.
    always_comb begin
        target = base_s;
        if ((mtvec[1:0] == MTVEC_VECTORED) && is_int) begin
            target = base_s + offset_s;
        end else begin
            target = base_s;
        end
    end

endmodule

// File: rtl/trap_ctrl.sv
// Trap sequencer: arbitrates exception/mret/interrupts at writeback, drives the
// CSR update command, flushes the pipeline and holds the fetch redirect.
module trap_ctrl
    import trap_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    trap_ctrl_if.slave bus
);

    trap_state_e          state_r;
    trap_state_e          state_nx_s;
    trap_kind_e           kind_r;
    trap_kind_e           kind_s;

    logic                 instr_s;
    logic                 exc_s;
    logic                 ret_s;
    logic                 tint_s;
    logic                 sint_s;
    logic                 accept_s;
    logic                 commit_s;
    logic                 redirect_done_s;
    logic                 is_int_s;
    logic                 flush_s;
    logic                 wb_ready_s;

    logic [CPU_WIDTH-1:0] cause_s;
    logic [CPU_WIDTH-1:0] epc_s;
    logic [CPU_WIDTH-1:0] target_s;
    logic [CPU_WIDTH-1:0] target_r;

    logic                 trap_valid_r;
    logic                 mret_valid_r;
    logic                 redirect_valid_r;
    logic                 int_block_r;
    logic                 busy_r;
    logic [CPU_WIDTH-1:0] trap_cause_r;
    logic [CPU_WIDTH-1:0] trap_epc_r;
    logic [CPU_WIDTH-1:0] redirect_pc_r;

    // Gating with reset keeps every output low while reset is held.
    assign instr_s = reset & bus.wb_valid & (bus.wb_ins != 32'd0);
    assign exc_s   = instr_s & bus.ex_req;
    assign ret_s   = instr_s & bus.mret_req;
    assign tint_s  = instr_s & bus.mtime_int & bus.mstatus_mie & bus.mie_mtie & ~int_block_r;
    assign sint_s  = instr_s & bus.msip & bus.mstatus_mie & bus.mie_msie & ~int_block_r;
    assign epc_s   = align4(bus.wb_pc);
    assign is_int_s = (kind_s == TINT) | (kind_s == SINT);

    // Priority select of the single event accepted this cycle.
    always_comb begin
        accept_s = 1'b0;
        kind_s   = EXC;
        if (state_r == IDLE) begin
            if (exc_s) begin
                accept_s = 1'b1;
                kind_s   = EXC;
            end else if (ret_s) begin
                accept_s = 1'b1;
                kind_s   = RET;
            end else if (tint_s) begin
                accept_s = 1'b1;
                kind_s   = TINT;
            end else if (sint_s) begin
                accept_s = 1'b1;
                kind_s   = SINT;
            end else begin
                accept_s = 1'b0;
                kind_s   = EXC;
            end
        end else begin
            accept_s = 1'b0;
            kind_s   = EXC;
        end
    end

    // mcause value for the selected event.
    always_comb begin
        cause_s = {CPU_WIDTH{1'b0}};
        case (kind_s)
            EXC:     cause_s = bus.ex_code;
            TINT:    cause_s = int_cause(TIMER_CAUSE);
            SINT:    cause_s = int_cause(SOFT_CAUSE);
            RET:     cause_s = {CPU_WIDTH{1'b0}};
            default: cause_s = {CPU_WIDTH{1'b0}};
        endcase
    end

    trap_vec_calc u_vec_calc (
        .mtvec      (bus.mtvec),
        .cause_code (cause_s[CPU_WIDTH-2:0]),
        .is_int     (is_int_s),
        .target     (target_s)
    );

    // Next state plus the combinational flush / commit handshake.
    always_comb begin
        state_nx_s      = state_r;
        flush_s         = 1'b1;
        wb_ready_s      = 1'b0;
        commit_s        = 1'b0;
        redirect_done_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_nx_s = (kind_s == RET) ? MRET : TRAP;
                    flush_s    = 1'b1;
                    wb_ready_s = 1'b0;
                    commit_s   = 1'b0;
                end else begin
                    state_nx_s = IDLE;
                    flush_s    = 1'b0;
                    wb_ready_s = reset;
                    commit_s   = instr_s;
                end
            end
            TRAP:    state_nx_s = REDIRECT;
            MRET:    state_nx_s = REDIRECT;
            REDIRECT: begin
                if (redirect_valid_r & bus.redirect_ready) begin
                    redirect_done_s = 1'b1;
                    state_nx_s      = IDLE;
                end else begin
                    redirect_done_s = 1'b0;
                    state_nx_s      = REDIRECT;
                end
            end
            default: state_nx_s = IDLE;
        endcase
    end

    // State register and busy flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            busy_r  <= (state_nx_s != IDLE);
        end
    end

    // Capture of the accepted event and the one-cycle CSR commands.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            kind_r       <= EXC;
            trap_cause_r <= {CPU_WIDTH{1'b0}};
            trap_epc_r   <= {CPU_WIDTH{1'b0}};
            target_r     <= {CPU_WIDTH{1'b0}};
            trap_valid_r <= 1'b0;
            mret_valid_r <= 1'b0;
        end else begin
            trap_valid_r <= accept_s & (kind_s != RET);
            mret_valid_r <= accept_s & (kind_s == RET);
            if (accept_s) begin
                kind_r       <= kind_s;
                trap_cause_r <= cause_s;
                trap_epc_r   <= epc_s;
                target_r     <= target_s;
            end
        end
    end

    // Redirect request; mepc is taken in the MRET cycle so a CSR write
    // landing alongside the return is already visible.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            redirect_valid_r <= 1'b0;
            redirect_pc_r    <= {CPU_WIDTH{1'b0}};
        end else begin
            case (state_r)
                TRAP: begin
                    redirect_valid_r <= 1'b1;
                    redirect_pc_r    <= target_r;
                end
                MRET: begin
                    redirect_valid_r <= 1'b1;
                    redirect_pc_r    <= bus.mepc;
                end
                REDIRECT: begin
                    if (redirect_done_s) begin
                        redirect_valid_r <= 1'b0;
                    end
                end
                default: redirect_valid_r <= 1'b0;
            endcase
        end
    end

    // Forward progress: one instruction must retire between two interrupts.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            int_block_r <= 1'b0;
        end else if (redirect_done_s && ((kind_r == TINT) || (kind_r == SINT))) begin
            int_block_r <= 1'b1;
        end else if (commit_s) begin
            int_block_r <= 1'b0;
        end
    end

    assign bus.wb_ready       = wb_ready_s;
    assign bus.flush          = flush_s;
    assign bus.trap_valid     = trap_valid_r;
    assign bus.trap_cause     = trap_cause_r;
    assign bus.trap_epc       = trap_epc_r;
    assign bus.mret_valid     = mret_valid_r;
    assign bus.redirect_valid = redirect_valid_r;
    assign bus.redirect_pc    = redirect_pc_r;
    assign bus.busy           = busy_r;

endmodule

// File: tb/tb_trap_ctrl.sv
// Bench for trap_ctrl: directed scenarios then random traffic against a
// transaction-level reference model.
module tb_trap_ctrl;
    import trap_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    trap_ctrl_if bus ();

    trap_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model: is a trap sequence in flight, which step, and what it carries.
    bit          m_in_seq;
    int          m_phase;
    bit          m_is_mret;
    bit          m_is_int;
    bit          m_block;
    logic [63:0] m_cause;
    logic [63:0] m_epc;
    logic [63:0] m_target;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_in_seq = 1'b0;
        m_phase  = 0;
        m_block  = 1'b0;
    endtask

    // 0 none, 1 exception, 2 mret, 3 timer, 4 software
    function automatic int cur_event();
        if (!(reset && bus.wb_valid && bus.wb_ins != 32'd0)) return 0;
        if (bus.ex_req) return 1;
        if (bus.mret_req) return 2;
        if (!m_block && bus.mstatus_mie) begin
            if (bus.mtime_int && bus.mie_mtie) return 3;
            if (bus.msip && bus.mie_msie) return 4;
        end
        return 0;
    endfunction

    function automatic logic [63:0] vec_target(input logic [63:0] tvec, input bit is_int,
                                               input logic [63:0] cause);
        logic [63:0] base;
        base = tvec - (tvec % 64'd4);
        if ((tvec % 64'd4) == 64'd1 && is_int) return base + 64'd4 * (cause - (64'd1 << 63));
        return base;
    endfunction

    task automatic model_compare();
        bit exp_tv, exp_mv, exp_rv, exp_flush;
        exp_tv    = m_in_seq && m_phase == 1 && !m_is_mret;
        exp_mv    = m_in_seq && m_phase == 1 && m_is_mret;
        exp_rv    = m_in_seq && m_phase == 2;
        exp_flush = m_in_seq || (cur_event() != 0);
        check_eq("busy", 64'(bus.busy), 64'(m_in_seq));
        check_eq("trap_valid", 64'(bus.trap_valid), 64'(exp_tv));
        check_eq("mret_valid", 64'(bus.mret_valid), 64'(exp_mv));
        check_eq("redirect_valid", 64'(bus.redirect_valid), 64'(exp_rv));
        check_eq("flush", 64'(bus.flush), 64'(exp_flush));
        check_eq("wb_ready", 64'(bus.wb_ready), 64'(!exp_flush));
        if (exp_tv) begin
            check_eq("trap_cause", bus.trap_cause, m_cause);
            check_eq("trap_epc", bus.trap_epc, m_epc);
        end
        if (exp_rv) check_eq("redirect_pc", bus.redirect_pc, m_target);
    endtask

    task automatic model_update();
        int ev;
        if (!m_in_seq) begin
            ev = cur_event();
            if (ev != 0) begin
                m_in_seq  = 1'b1;
                m_phase   = 1;
                m_is_mret = (ev == 2);
                m_is_int  = (ev >= 3);
                m_cause   = (ev == 1) ? bus.ex_code :
                            (ev == 3) ? (64'd1 << 63) + 64'd7 : (64'd1 << 63) + 64'd3;
                m_epc     = bus.wb_pc - (bus.wb_pc % 64'd4);
                if (!m_is_mret) m_target = vec_target(bus.mtvec, m_is_int, m_cause);
            end else if (bus.wb_valid && bus.wb_ins != 32'd0) begin
                m_block = 1'b0;
            end
        end else if (m_phase == 1) begin
            if (m_is_mret) m_target = bus.mepc;
            m_phase = 2;
        end else if (bus.redirect_ready) begin
            m_in_seq = 1'b0;
            if (m_is_int) m_block = 1'b1;
        end
    endtask

    // Called at a falling edge with inputs already driven; returns at the next falling edge.
    task automatic step();
        #1;
        model_compare();
        model_update();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive_quiet();
        bus.wb_valid       = 1'b0;
        bus.wb_ins         = 32'd0;
        bus.ex_req         = 1'b0;
        bus.mret_req       = 1'b0;
        bus.mtime_int      = 1'b0;
        bus.msip           = 1'b0;
        bus.mstatus_mie    = 1'b1;
        bus.mie_mtie       = 1'b1;
        bus.mie_msie       = 1'b1;
        bus.redirect_ready = 1'b1;
    endtask

    task automatic check_outputs_zero(input string tag);
        check_eq({tag, "_wb_ready"}, 64'(bus.wb_ready), 64'd0);
        check_eq({tag, "_flush"}, 64'(bus.flush), 64'd0);
        check_eq({tag, "_trap_valid"}, 64'(bus.trap_valid), 64'd0);
        check_eq({tag, "_trap_cause"}, bus.trap_cause, 64'd0);
        check_eq({tag, "_trap_epc"}, bus.trap_epc, 64'd0);
        check_eq({tag, "_mret_valid"}, 64'(bus.mret_valid), 64'd0);
        check_eq({tag, "_redirect_valid"}, 64'(bus.redirect_valid), 64'd0);
        check_eq({tag, "_redirect_pc"}, bus.redirect_pc, 64'd0);
        check_eq({tag, "_busy"}, 64'(bus.busy), 64'd0);
    endtask

    task automatic instr(input logic [63:0] pc);
        bus.wb_valid = 1'b1;
        bus.wb_ins   = 32'h0000_0013;
        bus.wb_pc    = pc;
    endtask

    initial begin
        drive_quiet();
        bus.wb_pc   = 64'h0;
        bus.ex_code = 64'h0;
        bus.mtvec   = 64'h8000_1000;
        bus.mepc    = 64'h0;
        model_reset();
        reset = 1'b1;
        #2 reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_outputs_zero("rst");
        reset = 1'b1;
        instr(64'h8000_0000);
        #1 check_eq("rst_release_wb_ready", 64'(bus.wb_ready), 64'd1);
        step();

        // Exception, direct mode, zero-wait redirect
        instr(64'h8000_0106);
        bus.ex_req  = 1'b1;
        bus.ex_code = 64'd11;
        bus.mtvec   = 64'h8000_1000;
        #1 check_eq("t1_flush_n", 64'(bus.flush), 64'd1);
        step();
        drive_quiet();
        check_eq("t1_trap_valid", 64'(bus.trap_valid), 64'd1);
        check_eq("t1_cause", bus.trap_cause, 64'd11);
        check_eq("t1_epc", bus.trap_epc, 64'h8000_0104);
        step();
        check_eq("t1_redirect_pc", bus.redirect_pc, 64'h8000_1000);
        step();
        check_eq("t1_busy_n3", 64'(bus.busy), 64'd0);
        step();

        // Timer interrupt, vectored mode
        instr(64'h8000_0200);
        bus.mtime_int = 1'b1;
        bus.mtvec     = 64'h8000_1001;
        step();
        bus.wb_valid = 1'b0;
        check_eq("t2_cause", bus.trap_cause, 64'h8000_0000_0000_0007);
        step();
        check_eq("t2_redirect_pc", bus.redirect_pc, 64'h8000_101C);
        step();

        // Forward progress: bubble, commit, then re-trap
        bus.wb_valid = 1'b1;
        bus.wb_ins   = 32'd0;
        #1 check_eq("t4_bubble_flush", 64'(bus.flush), 64'd0);
        step();
        instr(64'h8000_1000);
        #1 check_eq("t4_commit_ready", 64'(bus.wb_ready), 64'd1);
        step();
        instr(64'h8000_1004);
        #1 check_eq("t4_retrap_flush", 64'(bus.flush), 64'd1);
        step();
        drive_quiet();
        step();
        step();
        instr(64'h8000_1008);
        step();

        // Simultaneous exception, mret and timer
        instr(64'h8000_0300);
        bus.ex_req    = 1'b1;
        bus.mret_req  = 1'b1;
        bus.mtime_int = 1'b1;
        bus.ex_code   = 64'd2;
        step();
        bus.wb_valid = 1'b0;
        bus.ex_req   = 1'b0;
        bus.mret_req = 1'b0;
        check_eq("t3_trap_valid", 64'(bus.trap_valid), 64'd1);
        check_eq("t3_mret_valid", 64'(bus.mret_valid), 64'd0);
        check_eq("t3_cause", bus.trap_cause, 64'd2);
        step();
        check_eq("t3_redirect_pc", bus.redirect_pc, 64'h8000_1000);
        step();
        instr(64'h8000_1000);
        #1 check_eq("t3_timer_next", 64'(bus.flush), 64'd1);
        step();
        bus.wb_valid = 1'b0;
        check_eq("t3_timer_cause", bus.trap_cause, 64'h8000_0000_0000_0007);
        step();
        step();
        drive_quiet();
        instr(64'h8000_101C);
        step();

        // mret with a stalled fetch
        instr(64'h8000_0400);
        bus.mret_req       = 1'b1;
        bus.mepc           = 64'h8000_0200;
        bus.redirect_ready = 1'b0;
        step();
        bus.wb_valid = 1'b0;
        bus.mret_req = 1'b0;
        check_eq("t5_mret_valid", 64'(bus.mret_valid), 64'd1);
        step();
        for (int i = 0; i < 4; i++) begin
            check_eq("t5_hold_valid", 64'(bus.redirect_valid), 64'd1);
            check_eq("t5_hold_pc", bus.redirect_pc, 64'h8000_0200);
            check_eq("t5_mret_once", 64'(bus.mret_valid), 64'd0);
            step();
        end
        bus.redirect_ready = 1'b1;
        step();
        check_eq("t5_done_busy", 64'(bus.busy), 64'd0);

        // Reset in the middle of a redirect
        instr(64'h8000_0500);
        bus.ex_req = 1'b1;
        step();
        drive_quiet();
        bus.redirect_ready = 1'b0;
        step();
        step();
        bus.ex_req   = 1'b1;
        bus.wb_valid = 1'b1;
        bus.wb_ins   = 32'h0000_0073;
        #2 reset = 1'b0;
        #1 check_outputs_zero("t6_async");
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        drive_quiet();
        instr(64'h8000_0600);
        #1 check_eq("t6_wb_ready", 64'(bus.wb_ready), 64'd1);
        check_eq("t6_busy", 64'(bus.busy), 64'd0);
        step();

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            bus.wb_valid = ($urandom_range(0, 9) < 8);
            bus.wb_ins   = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
            bus.wb_pc    = {$urandom, $urandom};
            bus.ex_req   = ($urandom_range(0, 9) == 0);
            bus.mret_req = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 19) == 0) bus.mtime_int = ~bus.mtime_int;
            if ($urandom_range(0, 19) == 0) bus.msip = ~bus.msip;
            bus.mstatus_mie    = ($urandom_range(0, 7) != 0);
            bus.mie_mtie       = ($urandom_range(0, 3) != 0);
            bus.mie_msie       = ($urandom_range(0, 3) != 0);
            bus.mtvec          = {$urandom, $urandom};
            bus.mepc           = {$urandom, $urandom};
            bus.ex_code        = ($urandom_range(0, 1) == 0) ? 64'($urandom_range(0, 15))
                                                             : {$urandom, $urandom};
            bus.redirect_ready = ($urandom_range(0, 2) != 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
